// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 raster constants, counter type and window helper for the
// VGA timing generator and the display stages that consume its position.
package vga_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam bit VGA_HS_POL = 1'b0;
  localparam bit VGA_VS_POL = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  // Raw (active-high) sync pair carried through the delay line together.
  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  function automatic logic inWindow(cnt_t pos, int lo, int len);
    return (int'(pos) >= lo) && (int'(pos) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster position and sync bundle from the timing generator (master) to the
// pixel/display stage (slave).
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic pixel_tick;
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic visible;
  logic line_start;
  logic frame_start;
  logic hsync;
  logic vsync;

  modport master (
    output pixel_tick, h_cnt, v_cnt, visible, line_start, frame_start, hsync, vsync
  );

  modport slave (
    input pixel_tick, h_cnt, v_cnt, visible, line_start, frame_start, hsync, vsync
  );
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Tick-enabled shift register that realigns sync with downstream pipeline
// latency; DEPTH=0 is a plain wire.
module sync_delay_line #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unusedInputs;
    assign unusedInputs = &{1'b0, clk, rst, en};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] dlyStage_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) dlyStage_q[i] <= INIT;
      end else if (en) begin
        dlyStage_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) dlyStage_q[i] <= dlyStage_q[i-1];
      end
    end

    assign q = dlyStage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel divider, h/v counters,
// undelayed window decodes and tick-delayed, polarity-registered syncs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit HS_POL     = VGA_HS_POL,
  parameter bit VS_POL     = VGA_VS_POL,
  parameter int CLK_DIV    = 1,
  parameter int SYNC_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || CLK_DIV < 1 || SYNC_DELAY < 0)
  begin : g_param_check
    $error("vga_timing_gen: raster totals exceed counter range or bad divider/delay");
  end

  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  cnt_t             hCnt_q, hCnt_d;
  cnt_t             vCnt_q, vCnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             pixelTick;
  sync_t            rawSync;
  sync_t            dlySync;

  // Divider and raster counters advance together on the pixel strobe.
  always_comb begin
    pixelTick = (divCnt_q == DIV_W'(CLK_DIV - 1));
    divCnt_d  = pixelTick ? '0 : divCnt_q + DIV_W'(1);
    hCnt_d    = hCnt_q;
    vCnt_d    = vCnt_q;
    if (pixelTick) begin
      if (hCnt_q == cnt_t'(H_TOTAL - 1)) begin
        hCnt_d = '0;
        vCnt_d = (vCnt_q == cnt_t'(V_TOTAL - 1)) ? '0 : vCnt_q + cnt_t'(1);
      end else begin
        hCnt_d = hCnt_q + cnt_t'(1);
      end
    end
  end

  always_comb begin
    rawSync.hs = inWindow(hCnt_q, H_ACTIVE + H_FP, H_SYNC);
    rawSync.vs = inWindow(vCnt_q, V_ACTIVE + V_FP, V_SYNC);
    hsync_d    = dlySync.hs ? HS_POL : ~HS_POL;
    vsync_d    = dlySync.vs ? VS_POL : ~VS_POL;
  end

  sync_delay_line #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (SYNC_DELAY),
    .INIT  ('0)
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .en  (pixelTick),
    .d   (rawSync),
    .q   (dlySync)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divCnt_q <= '0;
      hCnt_q   <= '0;
      vCnt_q   <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
    end else begin
      divCnt_q <= divCnt_d;
      hCnt_q   <= hCnt_d;
      vCnt_q   <= vCnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign vga.pixel_tick  = pixelTick;
  assign vga.h_cnt       = hCnt_q;
  assign vga.v_cnt       = vCnt_q;
  assign vga.visible     = (hCnt_q < cnt_t'(H_ACTIVE)) && (vCnt_q < cnt_t'(V_ACTIVE));
  assign vga.line_start  = pixelTick && (hCnt_q == '0);
  assign vga.frame_start = pixelTick && (hCnt_q == '0) && (vCnt_q == '0);
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized reset-stress bench: a closed-form raster model fills a scoreboard
// that a negedge monitor drains against four differently configured generators.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int NDUT       = 4;
  localparam int RUN_CYCLES = 6000;

  localparam int S_HA = 16;
  localparam int S_HF = 2;
  localparam int S_HS = 3;
  localparam int S_HB = 3;
  localparam int S_VA = 6;
  localparam int S_VF = 1;
  localparam int S_VS = 2;
  localparam int S_VB = 1;

  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       vis;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
  } outs_t;

  typedef outs_t [NDUT-1:0] expSet_t;

  typedef struct {
    int hAct, hFp, hSync, hBp;
    int vAct, vFp, vSync, vBp;
    int div, dly;
    bit hsPol, vsPol;
  } cfg_t;

  logic    clk;
  logic    rst;
  outs_t   act [NDUT];
  cfg_t    cfg [NDUT];
  expSet_t expQ [$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      runLeft = 0;
  int      rstLeft = 3;
  bit      firstRelease = 1'b1;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if2 ();
  vga_timing_gen_if if3 ();

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .SYNC_DELAY(0)
  ) dut0 (.clk(clk), .rst(rst), .vga(if0));

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(1), .SYNC_DELAY(2)
  ) dut1 (.clk(clk), .rst(rst), .vga(if1));

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(4), .SYNC_DELAY(2)
  ) dut2 (.clk(clk), .rst(rst), .vga(if2));

  vga_timing_gen dut3 (.clk(clk), .rst(rst), .vga(if3));

  assign act[0] = {if0.pixel_tick, if0.h_cnt, if0.v_cnt, if0.visible,
                   if0.line_start, if0.frame_start, if0.hsync, if0.vsync};
  assign act[1] = {if1.pixel_tick, if1.h_cnt, if1.v_cnt, if1.visible,
                   if1.line_start, if1.frame_start, if1.hsync, if1.vsync};
  assign act[2] = {if2.pixel_tick, if2.h_cnt, if2.v_cnt, if2.visible,
                   if2.line_start, if2.frame_start, if2.hsync, if2.vsync};
  assign act[3] = {if3.pixel_tick, if3.h_cnt, if3.v_cnt, if3.visible,
                   if3.line_start, if3.frame_start, if3.hsync, if3.vsync};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed-form view: clk cycle c after release has completed c/div pixel
  // ticks; syncs reflect the raster position dly ticks and one clk earlier.
  function automatic outs_t modelOut(cfg_t k, bit inReset, int c);
    outs_t o;
    int hT, vT, p, h, v, q, pp;
    hT   = k.hAct + k.hFp + k.hSync + k.hBp;
    vT   = k.vAct + k.vFp + k.vSync + k.vBp;
    o.hs = ~k.hsPol;
    o.vs = ~k.vsPol;
    if (inReset) begin
      o.tick = (k.div == 1);
      o.h    = '0;
      o.v    = '0;
      o.vis  = 1'b1;
      o.ls   = o.tick;
      o.fs   = o.tick;
      return o;
    end
    p      = c / k.div;
    h      = p % hT;
    v      = (p / hT) % vT;
    o.tick = ((c % k.div) == k.div - 1);
    o.h    = 10'(h);
    o.v    = 10'(v);
    o.vis  = (h < k.hAct) && (v < k.vAct);
    o.ls   = o.tick && (h == 0);
    o.fs   = o.ls && (v == 0);
    if (c > 0) begin
      q = (c - 1) / k.div;
      if (q >= k.dly) begin
        pp = q - k.dly;
        if ((pp % hT) >= k.hAct + k.hFp && (pp % hT) < k.hAct + k.hFp + k.hSync)
          o.hs = k.hsPol;
        if (((pp / hT) % vT) >= k.vAct + k.vFp && ((pp / hT) % vT) < k.vAct + k.vFp + k.vSync)
          o.vs = k.vsPol;
      end
    end
    return o;
  endfunction

  task automatic applyStimulus();
    expSet_t e;
    if (rst) begin
      cyc++;
      if (runLeft == 0) begin
        rst     = 1'b0;
        rstLeft = $urandom_range(4, 1);
      end else begin
        runLeft--;
      end
    end else begin
      rstLeft--;
      if (rstLeft == 0) begin
        rst          = 1'b1;
        runLeft      = firstRelease ? 1200 : $urandom_range(1500, 200);
        firstRelease = 1'b0;
      end
    end
    if (!rst) cyc = 0;
    for (int i = 0; i < NDUT; i++) e[i] = modelOut(cfg[i], !rst, cyc);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(expSet_t e);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (act[i] !== e[i]) begin
        errors++;
        $display("[TB] FAIL dut%0d t=%0t actual(tick h v vis ls fs hs vs)=%b %0d %0d %b %b %b %b %b required=%b %0d %0d %b %b %b %b %b",
                 i, $time,
                 act[i].tick, act[i].h, act[i].v, act[i].vis, act[i].ls, act[i].fs, act[i].hs, act[i].vs,
                 e[i].tick, e[i].h, e[i].v, e[i].vis, e[i].ls, e[i].fs, e[i].hs, e[i].vs);
      end
    end
  endtask

  // Monitor samples mid-cycle, well away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    cfg[0] = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1, 0, 1'b0, 1'b0};
    cfg[1] = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1, 2, 1'b0, 1'b1};
    cfg[2] = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 4, 2, 1'b1, 1'b0};
    cfg[3] = '{VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP,
               VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP, 1, 2, VGA_HS_POL, VGA_VS_POL};
    rst = 1'b0;
    $display("[TB] starting %0d-cycle randomized reset/run sequence", RUN_CYCLES);
    repeat (RUN_CYCLES) begin
      @(posedge clk);
      #2;
      applyStimulus();
    end
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d entries left required=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator: the stage directly upstream of the pixel/image display stage. It produces the `h_cnt`/`v_cnt`/`visible` raster position consumed by the display stage and the `hsync`/`vsync` pins driven off-chip. Sync outputs are delayed by a programmable number of pixel ticks so they line up with the display stage's registered RGB and the frame-memory read latency. A clock divider lets the block run from a 25 MHz pixel clock or a faster system clock.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- `HS_POL` / `VS_POL`, 0 / 0, active level of hsync / vsync (0 = active-low)
- `CLK_DIV`, 1, `clk` cycles per pixel (1 means `clk` is the 25 MHz pixel clock; 4 means 100 MHz)
- `SYNC_DELAY`, 2, pixel-tick delay applied to `hsync`/`vsync` only (0 is legal)
- `clk`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pixel_tick`  out  1  one-`clk` strobe marking each pixel period; constant 1 when `CLK_DIV`=1
- `h_cnt`  out  10  horizontal position, 0..H_TOTAL-1
- `v_cnt`  out  10  vertical position, 0..V_TOTAL-1
- `visible`  out  1  `h_cnt`<H_ACTIVE and `v_cnt`<V_ACTIVE
- `line_start`  out  1  `pixel_tick` and `h_cnt`==0
- `frame_start`  out  1  `pixel_tick` and `h_cnt`==0 and `v_cnt`==0
- `hsync`  out  1  delayed horizontal sync, polarity per `HS_POL`
- `vsync`  out  1  delayed vertical sync, polarity per `VS_POL`

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Elaboration error if either total exceeds 1024.
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps. `pixel_tick` = (`div_cnt`==CLK_DIV-1).
- On a `pixel_tick` cycle:
  - `h_cnt` increments. At H_TOTAL-1 it wraps to 0, and `v_cnt` increments in the same cycle.
  - `v_cnt` wraps from V_TOTAL-1 to 0 when `h_cnt` also wraps.
  - Counters hold on all other cycles.
- Raw horizontal sync is active for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([656,751]).
- Raw vertical sync is active for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] ([490,491]), for the whole line.
- Raw syncs pass through a SYNC_DELAY-stage shift register that advances only on `pixel_tick`. Polarity is applied at the output, which is registered.
- `visible`, `line_start` and `frame_start` are combinational decodes of the registered counters and `div_cnt`. They are not delayed.

## Timing
- Reset (asserted, `rst`=0):
  - `div_cnt`, `h_cnt` and `v_cnt` are 0.
  - Every delay stage and the `hsync`/`vsync` outputs sit at the inactive level (1 for the default polarities).
  - `visible` is 1.
  - With `CLK_DIV`=1, `pixel_tick`, `line_start` and `frame_start` are 1 during reset; they are 0 otherwise.
- First cycle after reset release, `CLK_DIV`=1: `frame_start` is 1 and `h_cnt` becomes 1 on the next edge.
- `CLK_DIV`=N: the first `pixel_tick` is N-1 cycles after release.
- Frame period: H_TOTAL×V_TOTAL pixel ticks (420 000). `frame_start` is exactly one `clk` cycle wide per frame.
- Sync latency: `hsync` asserts SYNC_DELAY pixel ticks after `h_cnt` reaches 656, plus one `clk` for the output register. It stays asserted for exactly H_SYNC ticks; `vsync` likewise for V_SYNC lines.
- SYNC_DELAY=2 matches 1-cycle block-RAM read plus the display stage's registered RGB.
- Reset asserted mid-frame forces all state to its reset value immediately. There is no partial-line completion.

## Structure
- Package `vga_timing_pkg` holds:
  - the 640×480@60 constants (active, porches, sync, totals);
  - the sync polarity constants;
  - the counter width (10).
- Sub-module `sync_delay_line` (parameters WIDTH, DEPTH; inputs `clk`, `rst`, `en`, `d`; output `q`). It is a tick-enabled shift register with reset to a parameterised inactive value. DEPTH=0 passes through.
- The top module holds the divider, the counters, the window decodes and the output polarity registers.

## Test plan
- Reset and release, defaults: during reset `h_cnt`=`v_cnt`=0 and `hsync`=`vsync`=1. After release `h_cnt` steps 0,1,2 on consecutive cycles.
- Line wrap: at `h_cnt`=799, the next tick gives `h_cnt`=0, `v_cnt`+1, and `line_start`=1 for one cycle. At `v_cnt`=524 with `h_cnt`=799, the next tick gives (0,0) and `frame_start`=1.
- Sync windows, SYNC_DELAY=0:
  - `hsync` is low for exactly 96 ticks per line, starting one clk after `h_cnt`=656.
  - `vsync` is low for exactly 2×800 ticks per frame.
- SYNC_DELAY=2: the `hsync` falling edge moves exactly 2 ticks later than in the SYNC_DELAY=0 run; its width is unchanged.
- CLK_DIV=4: `pixel_tick` is high 1 cycle in 4, `h_cnt` increments every 4 clk, and the frame period is 1 680 000 clk.
- Mid-frame reset at `h_cnt`=300, `v_cnt`=200:
  - outputs return to their reset values asynchronously, without waiting for a `clk` edge;
  - the first frame after release has the full 420 000-tick period.
